// File: rtl/bibp_pkg.sv
// Shared opcode constants and opcode classification for the bibp ALU and its
// instruction queue.
package bibp_pkg;

    localparam logic [2:0] KOD_TOPLA = 3'b000;
    localparam logic [2:0] KOD_CIKAR = 3'b001;
    localparam logic [2:0] KOD_VE    = 3'b010;
    localparam logic [2:0] KOD_VEYA  = 3'b011;
    localparam logic [2:0] KOD_XOR   = 3'b100;

    function automatic logic kod_gecerli(input logic [2:0] kod);
        return kod <= KOD_XOR;
    endfunction

endpackage

// File: rtl/bibp.sv
// Combinational ALU: opcode in the top three bits, operand A in the upper half
// and operand B in the lower half of the data field; undefined opcodes give 0.
module bibp
    import bibp_pkg::*;
#(
    parameter int UZUNLUK = 8
) (
    input  logic [UZUNLUK+2:0] buyruk,
    output logic [UZUNLUK:0]   sonuc
);

    localparam int YARIM = UZUNLUK / 2;

    logic [2:0]       kod;
    logic [UZUNLUK:0] a;
    logic [UZUNLUK:0] b;

    assign kod = buyruk[UZUNLUK+2:UZUNLUK];
    assign a   = (UZUNLUK + 1)'(buyruk[UZUNLUK-1:YARIM]);
    assign b   = (UZUNLUK + 1)'(buyruk[YARIM-1:0]);

    always_comb begin
        sonuc = '0;
        case (kod)
            KOD_TOPLA: sonuc = a + b;
            KOD_CIKAR: sonuc = a - b;
            KOD_VE:    sonuc = a & b;
            KOD_VEYA:  sonuc = a | b;
            KOD_XOR:   sonuc = a ^ b;
            default:   sonuc = '0;
        endcase
    end

endmodule

// File: rtl/bibp_fifo.sv
// Power-of-two circular FIFO with wrapping pointers and a registered fill count;
// the head reads as zero while empty.
module bibp_fifo #(
    parameter int GENISLIK = 11,
    parameter int DERINLIK = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        yaz,
    input  logic [GENISLIK-1:0]         veri,
    input  logic                        oku,
    output logic [GENISLIK-1:0]         bas,
    output logic                        dolu,
    output logic                        bos,
    output logic [$clog2(DERINLIK):0]   doluluk
);

    localparam int AW = $clog2(DERINLIK);
    localparam logic [AW-1:0] ADIM     = AW'(1);
    localparam logic [AW:0]   SAY_ADIM = (AW + 1)'(1);
    localparam logic [AW:0]   TAM      = (AW + 1)'(DERINLIK);

    logic [GENISLIK-1:0] mem [DERINLIK];
    logic [AW-1:0]       yaz_ptr;
    logic [AW-1:0]       oku_ptr;
    logic                yaz_ok;
    logic                oku_ok;

    assign dolu   = (doluluk == TAM);
    assign bos    = (doluluk == '0);
    assign yaz_ok = yaz && !dolu;
    assign oku_ok = oku && !bos;
    assign bas    = bos ? '0 : mem[oku_ptr];

    // Storage needs no reset: stale entries are never visible because the
    // head is masked by the empty flag.
    always_ff @(posedge clk) begin
        if (yaz_ok) begin
            mem[yaz_ptr] <= veri;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
            doluluk <= '0;
        end else begin
            if (yaz_ok) begin
                yaz_ptr <= yaz_ptr + ADIM;
            end
            if (oku_ok) begin
                oku_ptr <= oku_ptr + ADIM;
            end
            case ({yaz_ok, oku_ok})
                2'b10:   doluluk <= doluluk + SAY_ADIM;
                2'b01:   doluluk <= doluluk - SAY_ADIM;
                default: doluluk <= doluluk;
            endcase
        end
    end

endmodule

// File: rtl/bibp_kuyruk.sv
// Instruction queue in front of the external bibp ALU plus the valid/ready
// result register behind it; also counts issued undefined opcodes.
module bibp_kuyruk
    import bibp_pkg::*;
#(
    parameter int UZUNLUK  = 8,
    parameter int DERINLIK = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [UZUNLUK+2:0]          giris_buyruk,
    input  logic                        giris_gecerli,
    output logic                        giris_hazir,
    output logic [UZUNLUK+2:0]          alu_buyruk,
    input  logic [UZUNLUK:0]            alu_sonuc,
    output logic [UZUNLUK:0]            cikis_sonuc,
    output logic                        cikis_gecerli,
    input  logic                        cikis_hazir,
    output logic [$clog2(DERINLIK):0]   doluluk,
    output logic [7:0]                  gecersiz_sayac
);

    logic dolu;
    logic bos;
    logic push;
    logic pop;

    // Ready looks only at the registered count, so a pop in the same cycle
    // never opens a slot combinationally.
    assign giris_hazir = rst_n && !dolu;
    assign push        = giris_gecerli && giris_hazir;
    assign pop         = !bos && (!cikis_gecerli || cikis_hazir);

    bibp_fifo #(
        .GENISLIK (UZUNLUK + 3),
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .yaz     (push),
        .veri    (giris_buyruk),
        .oku     (pop),
        .bas     (alu_buyruk),
        .dolu    (dolu),
        .bos     (bos),
        .doluluk (doluluk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cikis_sonuc    <= '0;
            cikis_gecerli  <= 1'b0;
            gecersiz_sayac <= '0;
        end else if (pop) begin
            cikis_sonuc   <= alu_sonuc;
            cikis_gecerli <= 1'b1;
            if (!kod_gecerli(alu_buyruk[UZUNLUK+2:UZUNLUK]) && gecersiz_sayac != 8'hFF) begin
                gecersiz_sayac <= gecersiz_sayac + 8'd1;
            end
        end else if (cikis_hazir) begin
            cikis_gecerli <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bibp_kuyruk.sv
// Randomized bench for bibp_kuyruk with the bibp ALU in the loop, checked
// against a queue-based reference model.
module tb_bibp_kuyruk;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] giris_buyruk = '0;
    logic        giris_gecerli = 1'b0;
    logic        giris_hazir;
    logic [10:0] alu_buyruk;
    logic [8:0]  alu_sonuc;
    logic [8:0]  cikis_sonuc;
    logic        cikis_gecerli;
    logic        cikis_hazir = 1'b0;
    logic [2:0]  doluluk;
    logic [7:0]  gecersiz_sayac;

    int          nvec = 0;
    int          nerr = 0;

    logic [10:0] m_q[$];
    logic        m_ov;
    logic [8:0]  m_res;
    int          m_cnt;
    logic [10:0] exp_bas;

    always #5 clk = ~clk;

    bibp_kuyruk #(.UZUNLUK(8), .DERINLIK(D)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .giris_buyruk   (giris_buyruk),
        .giris_gecerli  (giris_gecerli),
        .giris_hazir    (giris_hazir),
        .alu_buyruk     (alu_buyruk),
        .alu_sonuc      (alu_sonuc),
        .cikis_sonuc    (cikis_sonuc),
        .cikis_gecerli  (cikis_gecerli),
        .cikis_hazir    (cikis_hazir),
        .doluluk        (doluluk),
        .gecersiz_sayac (gecersiz_sayac)
    );

    bibp #(.UZUNLUK(8)) u_alu (
        .buyruk (alu_buyruk),
        .sonuc  (alu_sonuc)
    );

    // Reference ALU: A in [7:4], B in [3:0], nine-bit result.
    function automatic logic [8:0] ref_alu(input logic [10:0] w);
        int a;
        int b;
        a = int'(w[7:4]);
        b = int'(w[3:0]);
        case (w[10:8])
            3'd0:    return 9'(a + b);
            3'd1:    return 9'((a - b) & 511);
            3'd2:    return 9'(a & b);
            3'd3:    return 9'(a | b);
            3'd4:    return 9'(a ^ b);
            default: return 9'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ov  = 1'b0;
        m_res = '0;
        m_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model on the edge, settle.
    task automatic step(input logic v, input logic [10:0] w, input logic h);
        logic do_push;
        logic do_pop;
        giris_gecerli = v;
        giris_buyruk  = w;
        cikis_hazir   = h;
        @(posedge clk);
        do_push = v && (m_q.size() < D);
        do_pop  = (m_q.size() > 0) && (!m_ov || h);
        if (do_pop) begin
            m_res = ref_alu(m_q[0]);
            m_ov  = 1'b1;
            if (m_q[0][10:8] > 3'd4 && m_cnt < 255) m_cnt++;
            void'(m_q.pop_front());
        end else if (h) begin
            m_ov = 1'b0;
        end
        if (do_push) m_q.push_back(w);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        giris_gecerli = 1'b0;
        cikis_hazir   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (giris_hazir !== 1'b0 || alu_buyruk !== 11'd0 || doluluk !== 3'd0 ||
            cikis_gecerli !== 1'b0 || cikis_sonuc !== 9'd0 || gecersiz_sayac !== 8'd0) begin
            nerr++;
            $display("FAIL reset_state: hazir=%b buyruk=%h doluluk=%0d gecerli=%b sonuc=%0d sayac=%0d, want all 0",
                     giris_hazir, alu_buyruk, doluluk, cikis_gecerli, cikis_sonuc, gecersiz_sayac);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (giris_hazir !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release_hazir: got %b want 1", giris_hazir);
        end
    endtask

    task automatic test_basic();
        step(1'b1, 11'b000_0011_0101, 1'b1);
        nvec++;
        if (doluluk !== 3'd1 || cikis_gecerli !== 1'b0) begin
            nerr++;
            $display("FAIL basic_accept: doluluk=%0d gecerli=%b, want 1 0", doluluk, cikis_gecerli);
        end
        step(1'b0, 11'd0, 1'b1);
        nvec++;
        if (cikis_gecerli !== 1'b1 || cikis_sonuc !== 9'd8 || doluluk !== 3'd0) begin
            nerr++;
            $display("FAIL basic_result: gecerli=%b sonuc=%0d doluluk=%0d, want 1 8 0",
                     cikis_gecerli, cikis_sonuc, doluluk);
        end
        step(1'b0, 11'd0, 1'b1);
        nvec++;
        if (cikis_gecerli !== 1'b0 || cikis_sonuc !== 9'd8) begin
            nerr++;
            $display("FAIL basic_drain: gecerli=%b sonuc=%0d, want 0 8", cikis_gecerli, cikis_sonuc);
        end
    endtask

    task automatic test_full();
        logic [10:0] words [5];
        logic [8:0]  sonuclar [4];
        int          kabul;
        words = '{11'b000_0011_0101, 11'b001_1001_0100, 11'b010_1100_1010,
                  11'b011_0011_0100, 11'b100_0001_0001};
        sonuclar = '{9'd8, 9'd5, 9'd8, 9'd7};
        kabul = 0;
        // Occupy the output stage first (6 ^ 3 = 5) so the queue itself fills.
        step(1'b1, 11'b100_0110_0011, 1'b0);
        step(1'b0, 11'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (giris_hazir === 1'b1) kabul++;
            step(1'b1, words[i], 1'b0);
        end
        nvec++;
        if (kabul != 4 || doluluk !== 3'd4 || giris_hazir !== 1'b0 ||
            cikis_gecerli !== 1'b1 || cikis_sonuc !== 9'd5) begin
            nerr++;
            $display("FAIL full_stall: kabul=%0d doluluk=%0d hazir=%b gecerli=%b sonuc=%0d, want 4 4 0 1 5",
                     kabul, doluluk, giris_hazir, cikis_gecerli, cikis_sonuc);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 11'd0, 1'b1);
            nvec++;
            if (cikis_gecerli !== 1'b1 || cikis_sonuc !== sonuclar[i]) begin
                nerr++;
                $display("FAIL full_order[%0d]: gecerli=%b sonuc=%0d, want 1 %0d",
                         i, cikis_gecerli, cikis_sonuc, sonuclar[i]);
            end
        end
        step(1'b0, 11'd0, 1'b1);
        nvec++;
        if (cikis_gecerli !== 1'b0 || doluluk !== 3'd0) begin
            nerr++;
            $display("FAIL full_empty: gecerli=%b doluluk=%0d, want 0 0", cikis_gecerli, doluluk);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step(1'b1, {3'($urandom_range(0, 4)), 8'($urandom)}, 1'b0);
        nvec++;
        if (doluluk !== 3'd2 || cikis_gecerli !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_setup: doluluk=%0d gecerli=%b, want 2 1", doluluk, cikis_gecerli);
        end
        for (int i = 0; i < 14; i++) begin
            if (i < 10) step(1'b1, {3'($urandom_range(0, 4)), 8'($urandom)}, 1'b1);
            else        step(1'b0, 11'd0, 1'b1);
            nvec++;
            if ((i < 10 && doluluk !== 3'd2) || cikis_gecerli !== m_ov ||
                (m_ov && cikis_sonuc !== m_res) || doluluk !== 3'(m_q.size())) begin
                nerr++;
                $display("FAIL b2b[%0d]: doluluk=%0d gecerli=%b sonuc=%0d, want %0d %b %0d",
                         i, doluluk, cikis_gecerli, cikis_sonuc, m_q.size(), m_ov, m_res);
            end
        end
    endtask

    task automatic test_invalid();
        do_reset();
        step(1'b1, 11'b101_0001_0010, 1'b1);
        step(1'b1, 11'b110_0011_0100, 1'b1);
        step(1'b1, 11'b111_0101_0110, 1'b1);
        step(1'b0, 11'd0, 1'b1);
        nvec++;
        if (gecersiz_sayac !== 8'd3 || cikis_sonuc !== 9'd0) begin
            nerr++;
            $display("FAIL invalid_three: sayac=%0d sonuc=%0d, want 3 0", gecersiz_sayac, cikis_sonuc);
        end
        for (int i = 0; i < 300; i++) step(1'b1, {3'($urandom_range(5, 7)), 8'($urandom)}, 1'b1);
        step(1'b0, 11'd0, 1'b1);
        nvec++;
        if (gecersiz_sayac !== 8'd255 || m_cnt != 255) begin
            nerr++;
            $display("FAIL invalid_saturate: sayac=%0d model=%0d, want 255", gecersiz_sayac, m_cnt);
        end
    endtask

    task automatic test_wrap();
        int          gonderilen;
        logic [10:0] w;
        do_reset();
        gonderilen = 0;
        w = {3'($urandom_range(0, 4)), 8'($urandom)};
        for (int i = 0; i < 40; i++) begin
            logic hz;
            hz = giris_hazir;
            step(gonderilen < 9, w, (gonderilen >= 9) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (gonderilen < 9 && hz === 1'b1) begin
                gonderilen++;
                w = {3'($urandom_range(0, 4)), 8'($urandom)};
            end
            exp_bas = (m_q.size() != 0) ? m_q[0] : 11'd0;
            nvec++;
            if (cikis_gecerli !== m_ov || (m_ov && cikis_sonuc !== m_res) ||
                doluluk !== 3'(m_q.size()) || alu_buyruk !== exp_bas ||
                giris_hazir !== (m_q.size() < D)) begin
                nerr++;
                $display("FAIL wrap[%0d]: gecerli=%b sonuc=%0d doluluk=%0d buyruk=%h hazir=%b, want %b %0d %0d %h %b",
                         i, cikis_gecerli, cikis_sonuc, doluluk, alu_buyruk, giris_hazir,
                         m_ov, m_res, m_q.size(), exp_bas, m_q.size() < D);
            end
        end
        nvec++;
        if (gonderilen != 9 || doluluk !== 3'd0 || cikis_gecerli !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_done: sent=%0d doluluk=%0d gecerli=%b, want 9 0 0",
                     gonderilen, doluluk, cikis_gecerli);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 11'($urandom), (i >= 190) ? 1'b1 : 1'($urandom_range(0, 1)));
            exp_bas = (m_q.size() != 0) ? m_q[0] : 11'd0;
            nvec++;
            if (cikis_gecerli !== m_ov || (m_ov && cikis_sonuc !== m_res) ||
                doluluk !== 3'(m_q.size()) || gecersiz_sayac !== 8'(m_cnt) ||
                alu_buyruk !== exp_bas || giris_hazir !== (m_q.size() < D)) begin
                nerr++;
                $display("FAIL random[%0d]: gecerli=%b sonuc=%0d doluluk=%0d sayac=%0d buyruk=%h, want %b %0d %0d %0d %h",
                         i, cikis_gecerli, cikis_sonuc, doluluk, gecersiz_sayac, alu_buyruk,
                         m_ov, m_res, m_q.size(), m_cnt, exp_bas);
            end
        end
        repeat (6) step(1'b0, 11'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, {3'($urandom_range(0, 7)), 8'($urandom)}, 1'b0);
        nvec++;
        if (doluluk !== 3'd3 || cikis_gecerli !== 1'b1) begin
            nerr++;
            $display("FAIL midreset_setup: doluluk=%0d gecerli=%b, want 3 1", doluluk, cikis_gecerli);
        end
        #2;
        rst_n = 1'b0;
        giris_gecerli = 1'b0;
        model_reset();
        #1;
        nvec++;
        if (giris_hazir !== 1'b0 || alu_buyruk !== 11'd0 || doluluk !== 3'd0 ||
            cikis_gecerli !== 1'b0 || cikis_sonuc !== 9'd0 || gecersiz_sayac !== 8'd0) begin
            nerr++;
            $display("FAIL midreset_clear: hazir=%b buyruk=%h doluluk=%0d gecerli=%b sonuc=%0d sayac=%0d, want all 0",
                     giris_hazir, alu_buyruk, doluluk, cikis_gecerli, cikis_sonuc, gecersiz_sayac);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 11'b001_0111_0010, 1'b1);
        step(1'b0, 11'd0, 1'b1);
        nvec++;
        if (cikis_gecerli !== 1'b1 || cikis_sonuc !== 9'd5 || doluluk !== 3'd0) begin
            nerr++;
            $display("FAIL midreset_first: gecerli=%b sonuc=%0d doluluk=%0d, want 1 5 0",
                     cikis_gecerli, cikis_sonuc, doluluk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_invalid();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/bibp_kuyruk.md
# bibp_kuyruk

Instruction queue and result register that sits directly upstream and downstream of the `bibp` combinational ALU. It buffers incoming instruction words in a small FIFO and drives the FIFO head onto the ALU instruction input. It registers the ALU result into a valid/ready output stage and counts issued instructions that carry an undefined opcode. The ALU instance sits outside this block, between `alu_buyruk` and `alu_sonuc`.

## Interface
Parameters:
- `UZUNLUK`, 8, ALU data width; instruction word is `UZUNLUK+3` bits and result is `UZUNLUK+1` bits.
- `DERINLIK`, 4, FIFO depth in entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `giris_buyruk`  in  UZUNLUK+3  instruction word to enqueue.
- `giris_gecerli`  in  1  `giris_buyruk` is valid.
- `giris_hazir`  out  1  the queue can accept a word this cycle.
- `alu_buyruk`  out  UZUNLUK+3  FIFO head, driven to the ALU.
- `alu_sonuc`  in  UZUNLUK+1  combinational ALU result for `alu_buyruk`.
- `cikis_sonuc`  out  UZUNLUK+1  registered result.
- `cikis_gecerli`  out  1  `cikis_sonuc` is valid.
- `cikis_hazir`  in  1  downstream accepts the result.
- `doluluk`  out  $clog2(DERINLIK)+1  number of FIFO entries.
- `gecersiz_sayac`  out  8  count of issued undefined opcodes; saturates at 255.

## Operation
- **Opcode field:** `buyruk[UZUNLUK+2:UZUNLUK]`.
  - Defined opcodes: 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - Undefined opcodes: 101, 110, 111.
- **Push:** happens when `giris_gecerli && giris_hazir`. The word is written at the write pointer, which then increments.
- **`giris_hazir`:** equals `!dolu`, where `dolu` is `doluluk == DERINLIK`. It is forced to 0 while `rst_n` is low.
- **Pop (issue):** happens when `!bos && (!cikis_gecerli || cikis_hazir)`. On that edge:
  - `cikis_sonuc` is loaded from `alu_sonuc`.
  - `cikis_gecerli` is set to 1.
  - The read pointer increments.
  - If the head opcode is undefined, `gecersiz_sayac` increments, saturating at 255.
- **Output drain:** if `cikis_hazir` is high, `cikis_gecerli` is high and there is no pop, `cikis_gecerli` clears. `cikis_sonuc` holds its value.
- **`alu_buyruk`:** equals the FIFO head while the FIFO is not empty, and all zeros when it is empty.
- **Output stall:** while `cikis_gecerli && !cikis_hazir`, `cikis_sonuc` is held and no pop occurs.
- **Pointers:** width `$clog2(DERINLIK)`; they wrap modulo `DERINLIK`.
- **`doluluk` update:**
  - push only: +1
  - pop only: −1
  - push and pop in the same cycle: unchanged
- **Full FIFO with a pop in the same cycle:** no push is accepted. `giris_hazir` depends on the registered count only, with no combinational path from `cikis_hazir`.
- **Empty FIFO:** a word pushed on edge N is popped no earlier than edge N+1. There is no fall-through in the same cycle.

## Timing
- **Reset (asynchronous, while `rst_n` is low):**
  - pointers, `doluluk`, `cikis_sonuc`, `cikis_gecerli` and `gecersiz_sayac` are 0
  - `alu_buyruk` is 0
  - `giris_hazir` is 0
- `giris_hazir` goes to 1 in the first cycle after `rst_n` deasserts.
- **Latency:** a word accepted on edge N has its result valid after edge N+1, provided the output stage is free.
- **Throughput:** one instruction per cycle while `cikis_hazir` stays high.
- **Reset mid-operation:** FIFO contents are discarded and any pending result is lost. No partial state survives.
- **Combinational paths:**
  - `alu_buyruk` depends on registered state only.
  - `alu_sonuc` goes to registers only.
  - There is no input-to-output combinational path apart from the external ALU loop.

## Structure
- **Package `bibp_pkg`:**
  - opcode constants `KOD_TOPLA`, `KOD_CIKAR`, `KOD_VE`, `KOD_VEYA`, `KOD_XOR`
  - function `kod_gecerli(kod)`, which returns 1 for 000–100
- **Sub-module `bibp_fifo`:**
  - parameters `GENISLIK` and `DERINLIK`
  - push/pop interface with `dolu`, `bos`, `doluluk`, `bas`
  - `bibp_kuyruk` wraps it with the issue and output register logic
- **Bench:** instantiates `bibp` with `UZUNLUK=8` in the ALU loop. Instruction layout for tests: [10:8] opcode, [7:4] A, [3:0] B.

## Test plan
- Reset release, then push 11'b000_0011_0101 (add 3+5) with `cikis_hazir`=1 → `cikis_gecerli`=1 and `cikis_sonuc`=9'd8 one cycle after acceptance; `doluluk` returns to 0.
- Hold `cikis_hazir`=0, push 5 words → 4 accepted and `giris_hazir`=0 once `doluluk`=4. Release `cikis_hazir` → results in order: add 8, sub, and, or; no loss or duplication.
- Push and pop simultaneously at `doluluk`=2 for 10 cycles → `doluluk` stays 2; the result stream matches the input order.
- Issue opcodes 101, 110, 111 → `gecersiz_sayac`=3; 300 undefined issues → it saturates at 255.
- Wrap-around: push and drain 9 words with a depth of 4 → pointers wrap and all results match the reference model.
- Assert `rst_n`=0 with 3 entries queued and `cikis_gecerli`=1 → all outputs 0 immediately; after release, the first new word's result is correct.
